fir_frame_sequencer: RTL and testbench

//  Frame-level controller in front of one free-running FIR datapath (symmetric / adder-tree / direct form).

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_tag_pipe.sv | 31 +++
 rtl/fir_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR frame sequencer and its tag pipe.
package fir_pkg;

    localparam int FIR_WIDTH   = 16;
    localparam int FIR_TAPS    = 16;
    localparam int FIR_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        CLEAR = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic v;
        logic l;
    } tag_t;

    // One counter serves both the flush (TAPS-2 down to 0) and drain (LATENCY-1 down to 0) phases.
    function automatic int seq_cnt_width(input int taps, input int latency);
        int span;
        span = (taps > latency) ? taps : latency;
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/fir_tag_pipe.sv
// Delays the {valid,last} tag by LATENCY clocks so it lines up with the FIR output.
module fir_tag_pipe
    import fir_pkg::*;
#(
    parameter int LATENCY = FIR_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t pipe_r [LATENCY];

    // Shift register of tags, emptied by reset so no stale valid/last escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag_out = pipe_r[LATENCY-1];

endmodule

// File: rtl/fir_frame_sequencer.sv
// Frame controller feeding a free-running FIR: flush, drain, clear, and output tagging.
// Define FIR_SEQ_FLUSH_EN to keep the zero-flush tail; otherwise frames are truncated to N results.
module fir_frame_sequencer
    import fir_pkg::*;
#(
    parameter int WIDTH   = FIR_WIDTH,
    parameter int TAPS    = FIR_TAPS,
    parameter int LATENCY = FIR_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] fir_x,
    output logic             fir_clear,
    input  logic [WIDTH-1:0] fir_y,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             underrun,
    output logic             busy
);

    localparam int CNT_W = seq_cnt_width(TAPS, LATENCY);

    seq_state_t       state_r;
    seq_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] fir_x_r;
    logic [WIDTH-1:0] fir_x_s;
    tag_t             tag_r;
    tag_t             tag_s;
    tag_t             tag_q_s;
    logic             underrun_r;
    logic             underrun_s;
    logic             fir_clear_r;
    logic             s_ready_r;
    logic             busy_r;

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            fir_x_r     <= '0;
            tag_r       <= '0;
            underrun_r  <= 1'b0;
            fir_clear_r <= 1'b0;
            s_ready_r   <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            fir_x_r     <= fir_x_s;
            tag_r       <= tag_s;
            underrun_r  <= underrun_s;
            fir_clear_r <= (state_s == CLEAR);
            s_ready_r   <= (state_s == IDLE) || (state_s == RUN);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Next-state and phase counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE, RUN: begin
                if (s_valid && s_last) begin
`ifdef FIR_SEQ_FLUSH_EN
                    state_s = FLUSH;
                    cnt_s   = CNT_W'(TAPS - 2);
`else
                    state_s = DRAIN;
                    cnt_s   = CNT_W'(LATENCY - 1);
`endif
                end else if (s_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = state_r;
                end
            end
`ifdef FIR_SEQ_FLUSH_EN
            FLUSH: begin
                if (cnt_r == '0) begin
                    state_s = DRAIN;
                    cnt_s   = CNT_W'(LATENCY - 1);
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
`endif
            DRAIN: begin
                if (cnt_r == '0) begin
                    state_s = CLEAR;
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            CLEAR:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FIR sample, tag and sticky underrun for the coming cycle.
    always_comb begin
        fir_x_s    = '0;
        tag_s      = '0;
        underrun_s = underrun_r;
        case (state_r)
            IDLE: begin
                if (s_valid) begin
                    fir_x_s    = s_data;
                    tag_s.v    = 1'b1;
                    underrun_s = 1'b0;
`ifndef FIR_SEQ_FLUSH_EN
                    tag_s.l    = s_last;
`endif
                end else begin
                    fir_x_s    = '0;
                end
            end
            RUN: begin
                // A bubble still advances the FIR, so it is emitted as a zero result.
                tag_s.v = 1'b1;
                if (s_valid) begin
                    fir_x_s = s_data;
`ifndef FIR_SEQ_FLUSH_EN
                    tag_s.l = s_last;
`endif
                end else begin
                    underrun_s = 1'b1;
                end
            end
`ifdef FIR_SEQ_FLUSH_EN
            FLUSH: begin
                tag_s.v = 1'b1;
                tag_s.l = (cnt_r == '0);
            end
`endif
            default: begin
                fir_x_s = '0;
                tag_s   = '0;
            end
        endcase
    end

    fir_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .tag_in  (tag_r),
        .tag_out (tag_q_s)
    );

    assign s_ready   = s_ready_r;
    assign fir_x     = fir_x_r;
    assign fir_clear = fir_clear_r;
    assign m_valid   = tag_q_s.v;
    assign m_last    = tag_q_s.l;
    assign m_data    = fir_y;
    assign underrun  = underrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Bench: sequencer around a behavioural direct-form FIR; results checked against a convolution model.
module tb_fir_frame_sequencer;

    localparam int WIDTH   = 16;
    localparam int TAPS    = 16;
    localparam int LATENCY = 2;
    localparam int TIMEOUT = 200;
`ifdef FIR_SEQ_FLUSH_EN
    localparam int FLUSH_EN = 1;
`else
    localparam int FLUSH_EN = 0;
`endif
    localparam int H [TAPS] = '{1, 2, 3, 2, 1, 0, -1, -2, -1, 1, 2, 3, 2, 1, 1, 1};

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] fir_x;
    logic             fir_clear;
    logic [WIDTH-1:0] fir_y;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             underrun;
    logic             busy;

    exp_t exp_q[$];
    int   fd[$];
    bit   fg[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   clr_cnt = 0;

    fir_frame_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .fir_x     (fir_x),
        .fir_clear (fir_clear),
        .fir_y     (fir_y),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .underrun  (underrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural direct-form FIR with LATENCY clocks from fir_x to fir_y.
    logic [WIDTH-1:0] dl [TAPS-1];
    logic [WIDTH-1:0] yp [LATENCY];
    int               acc_s;

    always_comb begin
        acc_s = H[0] * int'($signed(fir_x));
        for (int k = 1; k < TAPS; k++) begin
            acc_s += H[k] * int'($signed(dl[k-1]));
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS-1; k++) dl[k] <= '0;
            for (int k = 0; k < LATENCY; k++) yp[k] <= '0;
        end else begin
            if (fir_clear) begin
                for (int k = 0; k < TAPS-1; k++) dl[k] <= '0;
            end else begin
                dl[0] <= fir_x;
                for (int k = 1; k < TAPS-1; k++) dl[k] <= dl[k-1];
            end
            yp[0] <= WIDTH'(acc_s);
            for (int k = 1; k < LATENCY; k++) yp[k] <= yp[k-1];
        end
    end

    assign fir_y = yp[LATENCY-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every emitted result against the head of the model queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && m_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_result: got data 0x%0h last %0b, expected no result (t=%0t)", m_data, m_last, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(e.data));
                check("m_last", 32'(m_last), 32'(e.last));
            end
        end
        if (reset === 1'b1 && fir_clear === 1'b1) clr_cnt++;
    end

    // Full (or truncated) convolution of the frame, bubbles counted as zero samples.
    task automatic build_expected();
        int   seq[$];
        int   nres;
        int   acc;
        exp_t e;
        for (int i = 0; i < fd.size(); i++) begin
            if (fg[i]) seq.push_back(0);
            seq.push_back(fd[i]);
        end
        nres = seq.size() + FLUSH_EN * (TAPS - 1);
        for (int j = 0; j < nres; j++) begin
            acc = 0;
            for (int k = 0; k < TAPS; k++) begin
                if (j - k >= 0 && j - k < seq.size()) acc += H[k] * seq[j-k];
            end
            e.data = WIDTH'(acc);
            e.last = (j == nres - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic make_random(input int n, input int gap_pct);
        fd.delete();
        fg.delete();
        for (int i = 0; i < n; i++) begin
            fd.push_back(int'($urandom_range(2000)) - 1000);
            fg.push_back(i > 0 && int'($urandom_range(99)) < gap_pct);
        end
    endtask

    function automatic bit any_gap();
        bit g;
        g = 1'b0;
        foreach (fg[i]) g |= fg[i];
        return g;
    endfunction

    // Drives the frame in fd/fg; stop_at >= 0 presents that sample and returns without a handshake.
    task automatic drive_frame(input int stop_at, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < fd.size(); i++) begin
            if (fg[i]) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = WIDTH'(fd[i]);
            s_last  = (i == fd.size() - 1);
            if (i == stop_at) return;
            w = 0;
            while (!s_ready && w < TIMEOUT) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= TIMEOUT) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ready_timeout: s_ready low for %0d cycles, expected acceptance", w);
            end
            if (i == 0) first_wait = w;
            @(posedge clk); #1;
            if (i == 0) check("underrun_clr_on_accept", 32'(underrun), 32'd0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_frame(input bit exp_ur, input int clr_exp);
        int w;
        w = 0;
        while (busy && w < TIMEOUT) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= TIMEOUT) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout: busy high for %0d cycles, expected drop", w);
        end
        check("results_outstanding", 32'(exp_q.size()), 32'd0);
        check("fir_clear_pulses", 32'(clr_cnt), 32'(clr_exp));
        check("underrun", 32'(underrun), 32'(exp_ur));
        check("s_ready_idle", 32'(s_ready), 32'd1);
    endtask

    initial begin
        int w;
        int clr0;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_fir_x", 32'(fir_x), 32'd0);
        check("rst_fir_clear", 32'(fir_clear), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Impulse
        fd = '{10000};
        fg = '{1'b0};
        build_expected();
        check("pin_impulse_count", 32'(exp_q.size()), 32'(1 + FLUSH_EN * 15));
        check("pin_impulse_first", 32'(exp_q[0].data), 32'd10000);
        check("pin_impulse_last", 32'(exp_q[exp_q.size()-1].last), 32'd1);
        clr0 = clr_cnt;
        drive_frame(-1, w);
        finish_frame(1'b0, clr0 + 1);

        // Gap-free step of 32 x 800
        fd.delete();
        fg.delete();
        for (int i = 0; i < 32; i++) begin
            fd.push_back(800);
            fg.push_back(1'b0);
        end
        build_expected();
        check("pin_step_count", 32'(exp_q.size()), 32'(32 + FLUSH_EN * 15));
        check("pin_step_steady", 32'(exp_q[20].data), 32'd12800);
        clr0 = clr_cnt;
        drive_frame(-1, w);
        finish_frame(1'b0, clr0 + 1);

        // Same step with one bubble before sample 10
        fg[10] = 1'b1;
        build_expected();
        check("pin_gap_count", 32'(exp_q.size()), 32'(33 + FLUSH_EN * 15));
        clr0 = clr_cnt;
        drive_frame(-1, w);
        finish_frame(1'b1, clr0 + 1);

        // Back-to-back frames, second held valid through the tail
        clr0 = clr_cnt;
        make_random(8, 0);
        build_expected();
        drive_frame(-1, w);
        make_random(5, 0);
        build_expected();
        drive_frame(-1, w);
        check("b2b_hold_cycles", 32'(w), 32'(FLUSH_EN * (TAPS - 1) + LATENCY + 1));
        finish_frame(1'b0, clr0 + 2);

        // Reset on the 5th sample of a 20-sample frame
        make_random(20, 0);
        build_expected();
        drive_frame(4, w);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_last", 32'(m_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clr0 = clr_cnt;
        make_random(6, 0);
        build_expected();
        drive_frame(-1, w);
        finish_frame(1'b0, clr0 + 1);

        // Randomised frames, some with bubbles
        for (int f = 0; f < 10; f++) begin
            clr0 = clr_cnt;
            make_random(int'($urandom_range(24, 1)), 15);
            build_expected();
            drive_frame(-1, w);
            finish_frame(any_gap(), clr0 + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

endmodule
